pipelined_ripple_adder: RTL and testbench

- Parametrised successor to the team's fixed 4-bit ripple-carry adder.
- Splits a WIDTH-bit add or subtract into STAGES ripple segments of SEG bits each, with one register stage per segment.
- Operands enter through a valid/ready handshake. Results leave through a second valid/ready handshake with backpressure.
- Intended as the datapath adder in ALU/accumulator blocks that need one result per cycle at high clock rates.

---
 rtl/adder_pkg.sv | 11 +
 rtl/carry_segment.sv | 27 ++
 rtl/pipelined_ripple_adder.sv | 127 ++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared adder constants: operation mode encoding and default datapath geometry.
// Combinational definitions only; no latency, no flow control.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

endpackage

// File: rtl/carry_segment.sv
// SEG-bit combinational ripple chain of full-adder cells.
// Zero latency; no flow control, the enclosing pipeline stage owns the handshake.
module carry_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  always_comb begin
    logic c;
    c        = ci;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Add/subtract split into WIDTH/SEG registered ripple segments; latency STAGES cycles, 1 beat/cycle.
// Whole pipeline (bubbles included) freezes while out_valid && !out_ready; in_ready mirrors that advance.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / SEG;
  // Operand skew is triangular: stage k only needs bits [WIDTH-1:k*SEG], packed back to back.
  localparam int SKEW_BITS = (STAGES > 1) ?
                             (STAGES - 1) * WIDTH - SEG * (STAGES - 1) * STAGES / 2 : 1;

  logic                           adv;
  logic [WIDTH-1:0]               b_eff;
  logic [STAGES-1:0]              vld_d, vld_q;
  logic [STAGES-1:0]              cy_d, cy_q;
  logic [STAGES-1:0][WIDTH-1:0]   sum_d, sum_q;
  logic [SKEW_BITS-1:0]           skew_a_d, skew_a_q;
  logic [SKEW_BITS-1:0]           skew_b_d, skew_b_q;
  logic                           ovf_d, ovf_q;

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;
  assign b_eff    = (sub == MODE_ADD) ? B : ~B;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RK = WIDTH - k * SEG;

    logic [RK-1:0]    a_src, b_src;
    logic [WIDTH-1:0] s_src;
    logic [SEG-1:0]   s_seg;
    logic             ci, co;

    if (k == 0) begin : g_head
      assign a_src    = A;
      assign b_src    = b_eff;
      assign s_src    = '0;
      assign ci       = (sub == MODE_SUB) ? 1'b1 : Cin;
      assign vld_d[k] = in_valid;
    end else begin : g_body
      localparam int OFF = (k - 1) * WIDTH - SEG * (k - 1) * k / 2;
      assign a_src    = skew_a_q[OFF +: RK];
      assign b_src    = skew_b_q[OFF +: RK];
      assign s_src    = sum_q[k-1];
      assign ci       = cy_q[k-1];
      assign vld_d[k] = vld_q[k-1];
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int NOFF = k * WIDTH - SEG * k * (k + 1) / 2;
      logic c_msb_unused;

      carry_segment #(.SEG(SEG)) u_seg (
        .a        (a_src[SEG-1:0]),
        .b        (b_src[SEG-1:0]),
        .ci       (ci),
        .s        (s_seg),
        .co       (co),
        .c_msb_in (c_msb_unused)
      );

      assign skew_a_d[NOFF +: RK-SEG] = a_src[RK-1:SEG];
      assign skew_b_d[NOFF +: RK-SEG] = b_src[RK-1:SEG];
    end else begin : g_tail
      logic c_msb;

      carry_segment #(.SEG(SEG)) u_seg (
        .a        (a_src[SEG-1:0]),
        .b        (b_src[SEG-1:0]),
        .ci       (ci),
        .s        (s_seg),
        .co       (co),
        .c_msb_in (c_msb)
      );

      assign ovf_d = c_msb ^ co;
    end

    assign cy_d[k]  = co;
    assign sum_d[k] = s_src | (WIDTH'(s_seg) << (k * SEG));
  end

  if (STAGES == 1) begin : g_noskew
    assign skew_a_d = '0;
    assign skew_b_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      cy_q     <= '0;
      sum_q    <= '0;
      skew_a_q <= '0;
      skew_b_q <= '0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      vld_q    <= vld_d;
      cy_q     <= cy_d;
      sum_q    <= sum_d;
      skew_a_q <= skew_a_d;
      skew_b_q <= skew_b_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign Sum       = sum_q[STAGES-1];
  assign Cout      = cy_q[STAGES-1];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder (WIDTH=16, SEG=4): arithmetic reference model plus directed literals.
// Randomized traffic with random backpressure; every output handshake is scored against the model queue.
module tb_pipelined_ripple_adder;

  localparam int W = 16;

  logic         clk, rst, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, Ovf;
  logic [W-1:0] A, B, Sum;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  pipelined_ripple_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // {Sum, Cout, Ovf} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic s);
    int full, sres;
    if (s) begin
      full = int'(a) + 65536 - int'(b);
      sres = int'($signed(a)) - int'($signed(b));
    end else begin
      full = int'(a) + int'(b) + int'(cin);
      sres = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    return {full[15:0], full >= 65536, (sres > 32767) || (sres < -32768)};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic         hold_pend;
    logic [W+1:0] held, got, e;
    hold_pend = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hold_pend = 1'b0;
      end else begin
        got = {Sum, Cout, Ovf};
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (hold_pend) check("stall_hold", {out_valid, got}, {1'b1, held});
        hold_pend = out_valid && !out_ready;
        held      = got;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
          else begin
            e = exp_q.pop_front();
            check("result", got, e);
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, sub));
      end
    end
  endtask

  // Starts and ends at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
    logic done;
    A = a; B = b; Cin = cin; sub = s; in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", in_ready, 1'b1);
  endtask

  task automatic one_beat(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic s,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    send(a, b, cin, s);
    n = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (out_valid) begin
        n = t;
        break;
      end
    end
    check({name, "_latency"}, n, 4);
    check({name, "_sum"}, Sum, es);
    check({name, "_cout"}, Cout, ec);
    check({name, "_ovf"}, Ovf, eo);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic acc, full;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", Sum, 16'h0000);
    check("rst_cout", Cout, 1'b0);
    check("rst_ovf", Ovf, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed literals
    one_beat("add_basic", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    one_beat("full_carry", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    one_beat("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    one_beat("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    one_beat("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1; A = 16'(i); B = 16'(i * 256); Cin = 1'b0; sub = 1'b0;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        for (int i = 0; i < 8; i++) begin
          check("stream_valid", out_valid, 1'b1);
          check("stream_sum", Sum, 16'(i * 257));
          @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;

    // Backpressure with a full pipeline
    out_ready = 1'b0;
    A = rand_op(); B = rand_op(); Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    full = 1'b0;
    for (int t = 0; t < 40 && !full; t++) begin
      @(negedge clk);
      acc  = in_ready;
      full = out_valid;
      if (!full) begin
        @(posedge clk); #1;
        if (acc) begin
          A = rand_op(); B = rand_op(); Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_depth", exp_q.size(), 4);
      @(negedge clk);
    end
    @(posedge clk); #1;
    drain("bp_no_loss");

    // Reset with beats in flight
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; A = 16'(i * 4369); B = 16'h0101; Cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", Sum, 16'h0000);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    one_beat("after_rst", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 4) != 0);
        A = rand_op(); B = rand_op();
        Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
    end
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
